iord_seq: RTL and testbench
===========================

# iord_seq

Memory-port sequencer for the multicycle datapath: owns the 3-bit memory-address mux select (`IorDControl`) and memory write strobe, arbitrating between instruction fetch, ALU-addressed loads/stores, RegA- and RegB-addressed accesses, and the exception-vector read. It holds each selected address stable for the memory wait window. It runs the fixed exception sequence: save EPC, read the vector from the cause constant address, then load the PC. It sits between the main control FSM and the address mux in front of memory.

## Interface
- `MEM_WAIT`, 2: extra cycles memory needs after address presentation; legal range 0..7.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch access request (address = PC); level, held until ack.
- `alu_req`  in  1  data access request (address = ALU result); level.
- `rega_req`  in  1  access request with address = RegA; level.
- `regb_req`  in  1  access request with address = RegB; level.
- `req_we`  in  1  write qualifier for the granted alu/rega/regb request; ignored for fetch.
- `exc_div0`, `exc_ovf`, `exc_noop`  in  1 each  exception pulses (divide by zero, overflow, illegal opcode).
- `IorDControl`  out  3  mux select: 000 PC, 001 Div0 const, 010 Ovf const, 011 NoOpcode const, 100 ALU, 101 RegA, 110 RegB.
- `mem_wr`  out  1  memory write enable.
- `ack`  out  4  one-hot completion pulse {regb, rega, alu, fetch}.
- `epc_wr`  out  1  EPC load strobe.
- `vec_load`  out  1  PC load-from-memory-data strobe.
- `exc_busy`  out  1  exception sequence in progress.

## Operation
- States: IDLE, ACCESS, EXC_EPC, EXC_READ, EXC_LOAD.
- Pending-exception register, 3 bits: ORs in exception inputs every cycle while not in EXC_EPC, EXC_READ or EXC_LOAD. Inputs arriving during those states are dropped.
- IDLE priority: pending exception > alu > rega > regb > fetch. Among exceptions: div0 > ovf > noop.
- IDLE with request only: latch grant and `req_we`, go to ACCESS, load wait counter with `MEM_WAIT`.
- ACCESS: `IorDControl` = granted source code. `mem_wr` = latched `req_we` in the first ACCESS cycle only. Counter decrements each cycle.
  - Counter = 0: pulse matching `ack` bit, return to IDLE.
- IDLE with pending exception: go to EXC_EPC, latch the highest-priority cause, clear all pending bits (lower causes are lost).
- EXC_EPC: one cycle. `epc_wr`=1, `IorDControl`=000.
- EXC_READ: `MEM_WAIT`+1 cycles. `IorDControl`=cause code (001/010/011).
- EXC_LOAD: one cycle. `vec_load`=1, `IorDControl` held at cause code. Return to IDLE.
- An exception raised during ACCESS waits until that access acks.
- Requests are never dropped. A request deasserted before ack still completes its access, and its ack pulse is ignored.
- Decoded select codes are 000..110; code 111 is never driven.

## Timing
- Reset values: `IorDControl`=000, `mem_wr`=0, `ack`=0000, `epc_wr`=0, `vec_load`=0, `exc_busy`=0, state IDLE, pending=000, counter=0.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- Access: request sampled at edge k; ACCESS cycles k+1 .. k+1+`MEM_WAIT`; `ack` high in the last ACCESS cycle.
- Request-to-ack minimum latency is `MEM_WAIT`+2 cycles.
- Back-to-back: the requester drops the request on the ack edge. The next grant is sampled in the following IDLE cycle, so there is one IDLE cycle between accesses.
- Exception sequence length: `MEM_WAIT`+3 cycles; `exc_busy` high for exactly those cycles.
- Reset asserted mid-sequence: immediate return to reset values; no `ack`, `epc_wr` or `vec_load` is emitted.

## Configuration
- `IORD_SEQ_CAUSE_EN` defined: adds output `exc_cause` (2 bits: 00 none, 01 div0, 10 ovf, 11 noop).
  - Set on entering EXC_EPC; holds the last serviced cause until reset.
  - Dropped exceptions (lost lower-priority or arriving during an exception) additionally set a sticky output `exc_lost`, cleared only by reset.
- `IORD_SEQ_CAUSE_EN` undefined: neither port exists; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - `IorDControl` code constants (SEL_PC .. SEL_REGB);
  - state enum;
  - cause encoding;
  - ack bit indices.
- One natural sub-module: `iord_arb`, the combinational fixed-priority encoder. Its inputs are pending exceptions and requests; its outputs are the grant code and the exception flag.

## Test plan
- `MEM_WAIT`=2, `fetch_req`=1 after reset: `IorDControl`=000 for 3 cycles, `ack`=0001 at cycle 4 after request, `mem_wr`=0 throughout.
- `alu_req`=1, `req_we`=1: `IorDControl`=100, `mem_wr`=1 only in the first ACCESS cycle, `ack`=0010 in the third ACCESS cycle.
- `fetch_req`, `rega_req` and `regb_req` all held, each dropped on its ack: grant order rega (101), regb (110), fetch (000), with one IDLE cycle between each.
- `exc_ovf` pulse during an alu access:
  - the access acks first;
  - then `epc_wr` for 1 cycle with select 000;
  - then select 010 for 3 cycles, then `vec_load` for 1 cycle;
  - `exc_busy` high for 5 cycles.
- `exc_div0` and `exc_noop` in the same cycle: select 001 serviced, noop dropped. With the macro on: `exc_cause`=01 and `exc_lost`=1.
- `reset` low during EXC_READ: all outputs return to reset values asynchronously, with no `vec_load` pulse after release.

Source files
------------

// File: rtl/iord_seq_pkg.sv
// Shared definitions for the iord_seq memory-port sequencer: select codes,
// FSM states, exception cause encoding and ack bit positions.
package iord_seq_pkg;

    localparam logic [2:0] SEL_PC   = 3'b000;
    localparam logic [2:0] SEL_DIV0 = 3'b001;
    localparam logic [2:0] SEL_OVF  = 3'b010;
    localparam logic [2:0] SEL_NOOP = 3'b011;
    localparam logic [2:0] SEL_ALU  = 3'b100;
    localparam logic [2:0] SEL_REGA = 3'b101;
    localparam logic [2:0] SEL_REGB = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_EXC_EPC,
        ST_EXC_READ,
        ST_EXC_LOAD
    } state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_DIV0 = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_NOOP = 2'b11;

    localparam int unsigned ACK_FETCH = 0;
    localparam int unsigned ACK_ALU   = 1;
    localparam int unsigned ACK_REGA  = 2;
    localparam int unsigned ACK_REGB  = 3;

endpackage

// File: rtl/iord_seq_if.sv
// Request/status bundle between the main control FSM (master) and iord_seq (slave).
// IORD_SEQ_CAUSE_EN adds exc_cause/exc_lost.
interface iord_seq_if;
    logic       fetch_req;
    logic       alu_req;
    logic       rega_req;
    logic       regb_req;
    logic       req_we;
    logic       exc_div0;
    logic       exc_ovf;
    logic       exc_noop;
    logic [2:0] IorDControl;
    logic       mem_wr;
    logic [3:0] ack;
    logic       epc_wr;
    logic       vec_load;
    logic       exc_busy;
`ifdef IORD_SEQ_CAUSE_EN
    logic [1:0] exc_cause;
    logic       exc_lost;

    modport master (
        output fetch_req, alu_req, rega_req, regb_req, req_we,
        output exc_div0, exc_ovf, exc_noop,
        input  IorDControl, mem_wr, ack, epc_wr, vec_load, exc_busy,
        input  exc_cause, exc_lost
    );
    modport slave (
        input  fetch_req, alu_req, rega_req, regb_req, req_we,
        input  exc_div0, exc_ovf, exc_noop,
        output IorDControl, mem_wr, ack, epc_wr, vec_load, exc_busy,
        output exc_cause, exc_lost
    );
`else
    modport master (
        output fetch_req, alu_req, rega_req, regb_req, req_we,
        output exc_div0, exc_ovf, exc_noop,
        input  IorDControl, mem_wr, ack, epc_wr, vec_load, exc_busy
    );
    modport slave (
        input  fetch_req, alu_req, rega_req, regb_req, req_we,
        input  exc_div0, exc_ovf, exc_noop,
        output IorDControl, mem_wr, ack, epc_wr, vec_load, exc_busy
    );
`endif
endinterface

// File: rtl/iord_seq_arb.sv
// iord_arb: combinational fixed-priority encoder.
// Order: div0 > ovf > noop > alu > rega > regb > fetch.
module iord_arb
    import iord_seq_pkg::*;
(
    input  logic [2:0] pend_i,     // {noop, ovf, div0}
    input  logic       alu_i,
    input  logic       rega_i,
    input  logic       regb_i,
    input  logic       fetch_i,
    output logic [2:0] sel_o,
    output logic       exc_o,
    output logic       vld_o
);

    always_comb begin
        sel_o = SEL_PC;
        exc_o = 1'b0;
        vld_o = 1'b1;
        if (pend_i[0]) begin
            sel_o = SEL_DIV0;
            exc_o = 1'b1;
        end else if (pend_i[1]) begin
            sel_o = SEL_OVF;
            exc_o = 1'b1;
        end else if (pend_i[2]) begin
            sel_o = SEL_NOOP;
            exc_o = 1'b1;
        end else if (alu_i) begin
            sel_o = SEL_ALU;
        end else if (rega_i) begin
            sel_o = SEL_REGA;
        end else if (regb_i) begin
            sel_o = SEL_REGB;
        end else begin
            vld_o = fetch_i;
        end
    end

endmodule

// File: rtl/iord_seq.sv
// iord_seq: memory-port sequencer driving the IorD address mux and write strobe,
// plus the EPC/vector exception sequence. Optional macro: IORD_SEQ_CAUSE_EN.
module iord_seq
    import iord_seq_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    iord_seq_if.slave   bus
);

    localparam logic [2:0] CNT_INIT = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [2:0] sel_q,   sel_d;
    logic       we_q,    we_d;
    logic [2:0] pend_q,  pend_d;

    logic [2:0] exc_in;
    logic [2:0] arb_sel;
    logic       arb_exc;
    logic       arb_vld;
    logic       in_exc;
    logic       take_exc;

    assign exc_in = {bus.exc_noop, bus.exc_ovf, bus.exc_div0};
    assign in_exc = (state_q == ST_EXC_EPC) || (state_q == ST_EXC_READ) ||
                    (state_q == ST_EXC_LOAD);
    assign take_exc = (state_q == ST_IDLE) && arb_exc;

    iord_arb u_arb (
        .pend_i  (pend_q),
        .alu_i   (bus.alu_req),
        .rega_i  (bus.rega_req),
        .regb_i  (bus.regb_req),
        .fetch_i (bus.fetch_req),
        .sel_o   (arb_sel),
        .exc_o   (arb_exc),
        .vld_o   (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        pend_d  = in_exc ? pend_q : (pend_q | exc_in);
        case (state_q)
            ST_IDLE: begin
                if (arb_exc) begin
                    // Older pending causes are discarded; this cycle's arrivals are kept.
                    state_d = ST_EXC_EPC;
                    sel_d   = arb_sel;
                    pend_d  = exc_in;
                end else if (arb_vld) begin
                    state_d = ST_ACCESS;
                    sel_d   = arb_sel;
                    we_d    = bus.req_we && (arb_sel != SEL_PC);
                    cnt_d   = CNT_INIT;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_EXC_EPC: begin
                state_d = ST_EXC_READ;
                cnt_d   = CNT_INIT;
            end
            ST_EXC_READ: begin
                if (cnt_q == 3'd0) state_d = ST_EXC_LOAD;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_EXC_LOAD: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_PC;
            we_q    <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            pend_q  <= pend_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.IorDControl = SEL_PC;
        bus.mem_wr      = 1'b0;
        bus.ack         = '0;
        bus.epc_wr      = 1'b0;
        bus.vec_load    = 1'b0;
        bus.exc_busy    = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                bus.IorDControl = sel_q;
                bus.mem_wr      = we_q && (cnt_q == CNT_INIT);
                if (cnt_q == 3'd0) begin
                    case (sel_q)
                        SEL_ALU:  bus.ack[ACK_ALU]   = 1'b1;
                        SEL_REGA: bus.ack[ACK_REGA]  = 1'b1;
                        SEL_REGB: bus.ack[ACK_REGB]  = 1'b1;
                        default:  bus.ack[ACK_FETCH] = 1'b1;
                    endcase
                end
            end
            ST_EXC_EPC: begin
                bus.epc_wr   = 1'b1;
                bus.exc_busy = 1'b1;
            end
            ST_EXC_READ: begin
                bus.IorDControl = sel_q;
                bus.exc_busy    = 1'b1;
            end
            ST_EXC_LOAD: begin
                bus.IorDControl = sel_q;
                bus.vec_load    = 1'b1;
                bus.exc_busy    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef IORD_SEQ_CAUSE_EN
    logic [1:0] cause_q;
    logic       lost_q;
    logic       lost_set;

    // Lost: several causes pending at grant, or any arrival while sequencing.
    assign lost_set = (take_exc && ($countones(pend_q) > 1)) || (in_exc && (exc_in != 3'b000));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_q <= CAUSE_NONE;
            lost_q  <= 1'b0;
        end else begin
            if (take_exc) cause_q <= arb_sel[1:0];
            if (lost_set) lost_q  <= 1'b1;
        end
    end

    assign bus.exc_cause = cause_q;
    assign bus.exc_lost  = lost_q;
`else
    logic unused_take;
    assign unused_take = take_exc;
`endif

endmodule

// File: tb/tb_iord_seq.sv
// Self-checking bench for iord_seq: directed scenarios then random traffic,
// every cycle compared against a transaction-level schedule model.
module tb_iord_seq;
    import iord_seq_pkg::*;

    localparam int unsigned MW = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic       wr;
        logic [3:0] ack;
        logic       epc;
        logic       vl;
        logic       busy;
    } vec_t;

    logic clk;
    logic reset;
    iord_seq_if bus ();

    iord_seq #(.MEM_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors;
    int   miscompares;
    vec_t q[$];
    logic [2:0] m_pend;
    logic [1:0] m_cause;
    logic       m_lost;
    logic [3:0] obs_ack;
    logic       obs_wr;
    logic       obs_busy;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_sel",  8'(bus.IorDControl), 8'h0);
        chk("rst_wr",   8'(bus.mem_wr),      8'h0);
        chk("rst_ack",  8'(bus.ack),         8'h0);
        chk("rst_epc",  8'(bus.epc_wr),      8'h0);
        chk("rst_vl",   8'(bus.vec_load),    8'h0);
        chk("rst_busy", 8'(bus.exc_busy),    8'h0);
`ifdef IORD_SEQ_CAUSE_EN
        chk("rst_cause", 8'(bus.exc_cause), 8'h0);
        chk("rst_lost",  8'(bus.exc_lost),  8'h0);
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_pend  = '0;
        m_cause = '0;
        m_lost  = 1'b0;
    endtask

    // Decide what the next edge launches, from the inputs of the current cycle.
    task automatic model_update();
        logic [2:0] ein;
        vec_t v;
        logic [2:0] c;
        logic [2:0] src;
        logic [3:0] abit;
        ein = {bus.exc_noop, bus.exc_ovf, bus.exc_div0};
        if (q.size() != 0) begin
            v = q.pop_front();
            if (v.busy) m_lost = m_lost | (ein != 3'b000);
            else        m_pend = m_pend | ein;
        end else if (m_pend != 3'b000) begin
            c = m_pend[0] ? 3'd1 : (m_pend[1] ? 3'd2 : 3'd3);
            if ($countones(m_pend) > 1) m_lost = 1'b1;
            m_cause = c[1:0];
            v = '0; v.epc = 1'b1; v.busy = 1'b1;
            q.push_back(v);
            for (int unsigned i = 0; i <= MW; i++) begin
                v = '0; v.sel = c; v.busy = 1'b1;
                q.push_back(v);
            end
            v = '0; v.sel = c; v.vl = 1'b1; v.busy = 1'b1;
            q.push_back(v);
            m_pend = ein;
        end else begin
            m_pend = m_pend | ein;
            if (bus.alu_req || bus.rega_req || bus.regb_req || bus.fetch_req) begin
                if (bus.alu_req)       begin src = 3'd4; abit = 4'b0010; end
                else if (bus.rega_req) begin src = 3'd5; abit = 4'b0100; end
                else if (bus.regb_req) begin src = 3'd6; abit = 4'b1000; end
                else                   begin src = 3'd0; abit = 4'b0001; end
                for (int unsigned i = 0; i <= MW; i++) begin
                    v = '0;
                    v.sel = src;
                    v.wr  = (i == 0) && bus.req_we && (src != 3'd0);
                    v.ack = (i == MW) ? abit : 4'b0000;
                    q.push_back(v);
                end
            end
        end
    endtask

    // One clock: check at negedge, advance model, return at posedge+1 with
    // pulses cleared and acked requests dropped.
    task automatic cycle();
        vec_t e;
        @(negedge clk);
        e = (q.size() != 0) ? q[0] : '0;
        chk("sel",  8'(bus.IorDControl), 8'(e.sel));
        chk("wr",   8'(bus.mem_wr),      8'(e.wr));
        chk("ack",  8'(bus.ack),         8'(e.ack));
        chk("epc",  8'(bus.epc_wr),      8'(e.epc));
        chk("vl",   8'(bus.vec_load),    8'(e.vl));
        chk("busy", 8'(bus.exc_busy),    8'(e.busy));
`ifdef IORD_SEQ_CAUSE_EN
        chk("cause", 8'(bus.exc_cause), 8'(m_cause));
        chk("lost",  8'(bus.exc_lost),  8'(m_lost));
`endif
        obs_ack  = bus.ack;
        obs_wr   = bus.mem_wr;
        obs_busy = bus.exc_busy;
        model_update();
        @(posedge clk);
        #1;
        bus.exc_div0 = 1'b0;
        bus.exc_ovf  = 1'b0;
        bus.exc_noop = 1'b0;
        if (obs_ack[0]) bus.fetch_req = 1'b0;
        if (obs_ack[1]) bus.alu_req   = 1'b0;
        if (obs_ack[2]) bus.rega_req  = 1'b0;
        if (obs_ack[3]) bus.regb_req  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || m_pend != 3'b000) && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 8'(q.size()), 8'h0);
    endtask

    initial begin
        int n;
        int lat;
        int cnt;
        logic [3:0] order[$];
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus.fetch_req = 1'b0; bus.alu_req = 1'b0; bus.rega_req = 1'b0; bus.regb_req = 1'b0;
        bus.req_we = 1'b0; bus.exc_div0 = 1'b0; bus.exc_ovf = 1'b0; bus.exc_noop = 1'b0;
        model_reset();
        #3;
        chk_reset_vals();
        @(posedge clk); #1;
        reset = 1'b1;
        cycle();

        // Fetch: ack MW+2 cycles after the request is first presented.
        bus.fetch_req = 1'b1;
        lat = 0;
        do begin cycle(); lat++; end while (obs_ack == 4'b0000 && lat < 20);
        chk("fetch_latency", 8'(lat), 8'(MW + 2));
        chk("fetch_ack", 8'(obs_ack), 8'b0001);
        cycle();

        // ALU write: exactly one mem_wr cycle.
        bus.alu_req = 1'b1; bus.req_we = 1'b1;
        cnt = 0; n = 0;
        do begin cycle(); n++; if (obs_wr) cnt++; end while (obs_ack == 4'b0000 && n < 20);
        bus.req_we = 1'b0;
        chk("alu_ack", 8'(obs_ack), 8'b0010);
        chk("alu_wr_cycles", 8'(cnt), 8'd1);
        cycle();

        // Three held requests: served rega, regb, fetch.
        bus.fetch_req = 1'b1; bus.rega_req = 1'b1; bus.regb_req = 1'b1;
        n = 0;
        while (order.size() < 3 && n < 40) begin
            cycle(); n++;
            if (obs_ack != 4'b0000) order.push_back(obs_ack);
        end
        chk("order_count", 8'(order.size()), 8'd3);
        if (order.size() == 3) begin
            chk("order_0", 8'(order[0]), 8'b0100);
            chk("order_1", 8'(order[1]), 8'b1000);
            chk("order_2", 8'(order[2]), 8'b0001);
        end
        drain();

        // Overflow during an ALU access: ack first, then MW+3 busy cycles.
        bus.alu_req = 1'b1;
        cycle(); cycle();
        bus.exc_ovf = 1'b1;
        cycle();
        cnt = 0; n = 0; lat = 0;
        while (n < 40 && !(cnt > 0 && !obs_busy)) begin
            cycle(); n++;
            if (obs_ack == 4'b0010 && cnt == 0) lat = 1;
            if (obs_busy) cnt++;
        end
        chk("ovf_after_ack", 8'(lat), 8'd1);
        chk("ovf_busy_len", 8'(cnt), 8'(MW + 3));
        drain();

        // div0 + noop together: div0 serviced, noop lost.
        bus.exc_div0 = 1'b1; bus.exc_noop = 1'b1;
        cycle();
        drain();
`ifdef IORD_SEQ_CAUSE_EN
        chk("dual_cause", 8'(bus.exc_cause), 8'b01);
        chk("dual_lost",  8'(bus.exc_lost),  8'b1);
`endif

        // Reset asserted during EXC_READ.
        bus.exc_ovf = 1'b1;
        cycle();
        n = 0;
        while (n < 20 && !(q.size() != 0 && q[0].busy && !q[0].epc && !q[0].vl)) begin
            cycle(); n++;
        end
        chk("reached_read", 8'(n < 20), 8'd1);
        #2 reset = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        reset = 1'b1;
        model_reset();
        repeat (6) cycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!bus.fetch_req && $urandom_range(0, 3) == 0) bus.fetch_req = 1'b1;
            if (!bus.alu_req   && $urandom_range(0, 5) == 0) bus.alu_req   = 1'b1;
            if (!bus.rega_req  && $urandom_range(0, 5) == 0) bus.rega_req  = 1'b1;
            if (!bus.regb_req  && $urandom_range(0, 5) == 0) bus.regb_req  = 1'b1;
            if ($urandom_range(0, 31) == 0) bus.alu_req = 1'b0;
            bus.req_we   = 1'($urandom_range(0, 1));
            bus.exc_div0 = ($urandom_range(0, 39) == 0);
            bus.exc_ovf  = ($urandom_range(0, 39) == 0);
            bus.exc_noop = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
